// File: rtl/rs_latch_if.sv
// Command and latch-drive bundle between a controller and rs_latch_driver.
// The master issues commands and returns latch feedback; the slave drives the latches.
interface rs_latch_if;
  logic       req;
  logic [1:0] cmd;
  logic [1:0] sel;
  logic [3:0] q_fb;
  logic [3:0] r;
  logic [3:0] s;
  logic [3:0] e;
  logic       ack;
  logic       busy;
  logic       err;

  modport master (
    output req, cmd, sel, q_fb,
    input  r, s, e, ack, busy, err
  );

  modport slave (
    input  req, cmd, sel, q_fb,
    output r, s, e, ack, busy, err
  );
endinterface

// File: rtl/rs_latch_driver.sv
// Sequencer for four gated RS latches: setup, enable pulse, hold, settle,
// then a feedback check. All outputs are registered from next-state values.
module rs_latch_driver #(
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned SETTLE  = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  rs_latch_if.slave bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SETUP    = 3'd1;
  localparam logic [2:0] PULSE    = 3'd2;
  localparam logic [2:0] HOLD     = 3'd3;
  localparam logic [2:0] SETTLE_W = 3'd4;
  localparam logic [2:0] CHECK    = 3'd5;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_SET  = 2'b01;
  localparam logic [1:0] CMD_RST  = 2'b10;
  localparam logic [1:0] CMD_TGL  = 2'b11;

  localparam logic [3:0] PW_M1 = 4'(PULSE_W - 1);
  localparam logic [3:0] ST_M1 = 4'(SETTLE - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic       tgt_q, tgt_d;
  logic       hold_q, hold_d;

  logic [3:0] r_q, r_d;
  logic [3:0] s_q, s_d;
  logic [3:0] e_q, e_d;
  logic       ack_q, ack_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;

  logic       fb_bit;
  logic       tgt_new;
  logic       drive;
  logic [3:0] one_hot;

  assign fb_bit = bus.q_fb[bus.sel];

  always_comb begin
    tgt_new = fb_bit;
    unique case (1'b1)
      bus.cmd == CMD_SET: tgt_new = 1'b1;
      bus.cmd == CMD_RST: tgt_new = 1'b0;
      bus.cmd == CMD_TGL: tgt_new = ~fb_bit;
      bus.cmd == CMD_HOLD: tgt_new = fb_bit;
    endcase
  end

  // Hold also passes a quiet SETUP cycle so its ACK lands two cycles after REQ.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    tgt_d   = tgt_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          sel_d   = bus.sel;
          tgt_d   = tgt_new;
          hold_d  = (bus.cmd == CMD_HOLD);
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (hold_q) begin
          state_d = CHECK;
        end else begin
          state_d = PULSE;
          cnt_d   = PW_M1;
        end
      end
      PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        state_d = SETTLE_W;
        cnt_d   = ST_M1;
      end
      SETTLE_W: begin
        if (cnt_q == 4'd0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CHECK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    one_hot = 4'b0001 << sel_d;
    drive   = !hold_d &&
              ((state_d == SETUP) ||
               (state_d == PULSE) ||
               (state_d == HOLD));
    s_d     = (drive && tgt_d) ? one_hot : 4'b0000;
    r_d     = (drive && !tgt_d) ? one_hot : 4'b0000;
    e_d     = (state_d == PULSE) ? one_hot : 4'b0000;
    ack_d   = (state_d == CHECK);
    busy_d  = (state_d != IDLE);
    err_d   = (state_d == CHECK) &&
              (bus.q_fb[sel_d] != tgt_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sel_q   <= 2'd0;
      tgt_q   <= 1'b0;
      hold_q  <= 1'b0;
      r_q     <= 4'b0000;
      s_q     <= 4'b0000;
      e_q     <= 4'b0000;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
      hold_q  <= hold_d;
      r_q     <= r_d;
      s_q     <= s_d;
      e_q     <= e_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.r    = r_q;
  assign bus.s    = s_q;
  assign bus.e    = e_q;
  assign bus.ack  = ack_q;
  assign bus.busy = busy_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_rs_latch_driver.sv
// Randomized bench for rs_latch_driver against a per-command timeline model
// with four behavioural gated RS latches attached.
module tb_rs_latch_driver;

  localparam int unsigned PW = 2;
  localparam int unsigned ST = 1;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] s;
    logic [3:0] e;
    logic       ack;
    logic       busy;
    logic       err;
  } ent_t;

  logic clk;
  logic rst_n;
  logic [3:0] q_lat;
  logic [3:0] stuck;

  int n_chk;
  int n_err;

  ent_t exp_q[$];
  ent_t cur;

  rs_latch_if bus();

  rs_latch_driver #(
    .PULSE_W(PW),
    .SETTLE (ST)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign bus.q_fb = q_lat & ~stuck;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Timeline of expected outputs for one accepted command.
  task automatic build(input logic [1:0] c,
                       input logic [1:0] sl,
                       input logic [3:0] fb);
    logic t;
    logic [3:0] oh;
    logic [3:0] sv;
    logic [3:0] rv;
    logic ex_err;
    oh = 4'b0001 << sl;
    case (c)
      2'd1: t = 1'b1;
      2'd2: t = 1'b0;
      2'd3: t = ~fb[sl];
      default: t = fb[sl];
    endcase
    ex_err = stuck[sl] && t;
    if (c == 2'd0) begin
      exp_q.push_back('{4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0});
      exp_q.push_back('{4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0});
    end else begin
      sv = t ? oh : 4'h0;
      rv = t ? 4'h0 : oh;
      exp_q.push_back('{rv, sv, 4'h0, 1'b0, 1'b1, 1'b0});
      for (int i = 0; i < PW; i++)
        exp_q.push_back('{rv, sv, oh, 1'b0, 1'b1, 1'b0});
      exp_q.push_back('{rv, sv, 4'h0, 1'b0, 1'b1, 1'b0});
      for (int i = 0; i < ST; i++)
        exp_q.push_back('{4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0});
      exp_q.push_back('{4'h0, 4'h0, 4'h0, 1'b1, 1'b1, ex_err});
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      cur = '0;
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
    end else if (!cur.busy && bus.req) begin
      build(bus.cmd, bus.sel, bus.q_fb);
      cur = exp_q.pop_front();
    end else begin
      cur = '0;
    end
  end

  // Gated RS latches: transparent while enabled.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.e[i]) begin
        if (bus.s[i]) q_lat[i] = 1'b1;
        else if (bus.r[i]) q_lat[i] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("r", 32'(bus.r), 32'(cur.r));
    chk("s", 32'(bus.s), 32'(cur.s));
    chk("e", 32'(bus.e), 32'(cur.e));
    chk("ack", 32'(bus.ack), 32'(cur.ack));
    chk("busy", 32'(bus.busy), 32'(cur.busy));
    chk("err", 32'(bus.err), 32'(cur.err));
    chk("rs_overlap", 32'(bus.r & bus.s), 32'd0);
  end

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic run(input logic [1:0] c, input logic [1:0] sl);
    @(negedge clk);
    bus.req = 1'b1;
    bus.cmd = c;
    bus.sel = sl;
    @(negedge clk);
    bus.req = 1'b0;
    wait_idle("run_timeout");
  endtask

  initial begin
    bit seen;
    n_chk   = 0;
    n_err   = 0;
    q_lat   = 4'h0;
    stuck   = 4'h0;
    bus.req = 1'b0;
    bus.cmd = 2'd0;
    bus.sel = 2'd0;
    cur     = '0;
    rst_n   = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rse", 32'({bus.r, bus.s, bus.e}), 32'd0);
    chk("rst_flags", 32'({bus.ack, bus.busy, bus.err}), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    run(2'd1, 2'd2);
    #1 chk("set2_q", 32'(bus.q_fb[2]), 32'd1);

    run(2'd1, 2'd0);
    run(2'd1, 2'd1);
    run(2'd1, 2'd3);
    #1 chk("all_set", 32'(bus.q_fb), 32'hf);
    run(2'd3, 2'd0);
    #1 chk("toggle0", 32'(bus.q_fb), 32'he);

    run(2'd0, 2'd3);
    #1 chk("hold3", 32'(bus.q_fb), 32'he);

    stuck = 4'b0010;
    run(2'd1, 2'd1);
    stuck = 4'b0000;

    @(negedge clk);
    bus.req = 1'b1;
    for (int i = 0; i < 60; i++) begin
      bus.cmd = 2'($urandom);
      bus.sel = 2'($urandom);
      @(negedge clk);
    end
    bus.req = 1'b0;
    wait_idle("b2b_timeout");

    @(negedge clk);
    bus.req = 1'b1;
    bus.cmd = 2'd1;
    bus.sel = 2'd1;
    @(negedge clk);
    bus.req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.e != 4'h0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("pulse_seen", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_e", 32'(bus.e), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_ack", 32'(bus.ack), 32'd0);
    @(negedge clk);
    bus.req = 1'b1;
    bus.cmd = 2'd2;
    bus.sel = 2'd1;
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("first_req", 32'(bus.busy), 32'd1);
    bus.req = 1'b0;
    wait_idle("post_rst_timeout");
    #1 chk("reset1_q", 32'(bus.q_fb[1]), 32'd0);

    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      bus.req = ($urandom_range(0, 2) == 0);
      bus.cmd = 2'($urandom);
      bus.sel = 2'($urandom);
      if (!bus.busy && $urandom_range(0, 15) == 0) begin
        stuck   = 4'($urandom);
        bus.req = 1'b0;
      end
    end
    bus.req = 1'b0;
    wait_idle("rand_timeout");
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
